mult_share_arbiter: RTL and testbench

MULT_SHARE_ARBITER -- requirements
Module: mult_share_arbiter

---
 rtl/mult_pkg.sv | 14 +
 rtl/mult_share_arbiter_if.sv | 28 ++
 rtl/mult_core.sv | 47 ++++
 rtl/mult_share_arbiter.sv | 126 ++++++++++++
 tb/tb_mult_share_arbiter.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared defaults and FSM state type for the shared-multiplier arbiter.
// Imported by the interface, the datapath core and the top.
package mult_pkg;

  localparam int MULT_NREQ = 4;
  localparam int MULT_W    = 4;
  localparam int PROD_W    = 2 * MULT_W;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/mult_share_arbiter_if.sv
// Requester-side bus of the shared multiplier: request levels, packed
// operands, grant/done pulses, product and busy.
interface mult_share_arbiter_if
  import mult_pkg::*;
#(
  parameter int NREQ = MULT_NREQ,
  parameter int W    = MULT_W
);

  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] opa;
  logic [NREQ*W-1:0] opb;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic [2*W-1:0]    product;
  logic              busy;

  modport master (
    output req, opa, opb,
    input  gnt, done, product, busy
  );

  modport slave (
    input  req, opa, opb,
    output gnt, done, product, busy
  );

endinterface

// File: rtl/mult_core.sv
// Shift-add multiplier datapath: one iteration per step, W steps per op.
// acc is the accumulator value after the current step.
module mult_core
  import mult_pkg::*;
#(
  parameter int W = MULT_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           step,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] acc,
  output logic           last_iter
);

  localparam int CW = $clog2(W + 1);

  logic [2*W-1:0] mcand_q;
  logic [W-1:0]   mplier_q;
  logic [2*W-1:0] acc_q;
  logic [CW-1:0]  cnt_q;

  assign acc       = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign last_iter = (cnt_q == CW'(W - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (start) begin
      mcand_q  <= {{W{1'b0}}, a};
      mplier_q <= b;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (step) begin
      acc_q    <= acc;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// NREQ requesters share one shift-add multiplier; round-robin by default,
// fixed priority (lowest index) when MULT_ARB_FIXED_PRIO_EN is defined.
module mult_share_arbiter
  import mult_pkg::*;
#(
  parameter int NREQ = MULT_NREQ,
  parameter int W    = MULT_W
) (
  input logic                 clk,
  input logic                 rst,
  mult_share_arbiter_if.slave bus
);

  localparam int IW = $clog2(NREQ);

  state_e          state_q;
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] done_q;
  logic [2*W-1:0]  product_q;
  logic [IW-1:0]   win_q;
  logic [IW-1:0]   win_d;

  logic            start;
  logic            step;
  logic            last_iter;
  logic [W-1:0]    a_sel;
  logic [W-1:0]    b_sel;
  logic [2*W-1:0]  acc;

  logic [W-1:0] opa_a [NREQ];
  logic [W-1:0] opb_a [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_ops
    assign opa_a[g] = bus.opa[g*W +: W];
    assign opb_a[g] = bus.opb[g*W +: W];
  end

`ifdef MULT_ARB_FIXED_PRIO_EN
  // Descending scan so the lowest requesting index is written last.
  always_comb begin
    win_d = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req[i]) win_d = IW'(i);
    end
  end
`else
  logic [IW-1:0]     last_q;
  logic [2*NREQ-1:0] dbl;
  logic              found;

  // Doubled request vector: scanning above last_q wraps around once.
  always_comb begin
    dbl   = {bus.req, bus.req};
    win_d = '0;
    found = 1'b0;
    for (int i = 0; i < 2 * NREQ; i++) begin
      if (!found && dbl[i] && (i > int'(last_q))) begin
        win_d = IW'((i >= NREQ) ? (i - NREQ) : i);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= IW'(NREQ - 1);
    end else if (start) begin
      last_q <= win_d;
    end
  end
`endif

  assign start = (state_q == IDLE) && (|bus.req);
  assign step  = (state_q == RUN);
  assign a_sel = opa_a[win_d];
  assign b_sel = opb_a[win_d];

  mult_core #(
    .W(W)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .step     (step),
    .a        (a_sel),
    .b        (b_sel),
    .acc      (acc),
    .last_iter(last_iter)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      done_q    <= '0;
      product_q <= '0;
      win_q     <= '0;
    end else begin
      gnt_q  <= '0;
      done_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (|bus.req) begin
            state_q <= RUN;
            gnt_q   <= {{(NREQ-1){1'b0}}, 1'b1} << win_d;
            win_q   <= win_d;
          end
        end
        RUN: begin
          if (last_iter) begin
            state_q   <= IDLE;
            product_q <= acc;
            done_q    <= {{(NREQ-1){1'b0}}, 1'b1} << win_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;
  assign bus.busy    = (state_q == RUN);

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Randomized scoreboard bench for mult_share_arbiter; the reference model
// predicts grants, done pulses and products from arbitration rules.
module tb_mult_share_arbiter;
  import mult_pkg::*;

  localparam int NREQ = MULT_NREQ;
  localparam int W    = MULT_W;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mult_share_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

  mult_share_arbiter #(
    .NREQ(NREQ),
    .W   (W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int en;
    int win;
    int prod;
  } exp_t;

  exp_t gq[$];
  exp_t dq[$];

  logic [W-1:0]    a_arr [NREQ];
  logic [W-1:0]    b_arr [NREQ];
  logic [NREQ-1:0] req_v;

  int n_chk  = 0;
  int n_fail = 0;
  int ecnt   = 0;
  int prod_m = 0;
  int prod_p = 0;
  bit m_busy = 1'b0;
  int m_last = NREQ - 1;
  int m_done = 0;

  function automatic void check(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)",
               name, act, exp, ecnt);
    end
  endfunction

  task automatic drive();
    logic [NREQ*W-1:0] pa;
    logic [NREQ*W-1:0] pb;
    pa = '0;
    pb = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      pa = {pa[NREQ*W-W-1:0], a_arr[i]};
      pb = {pb[NREQ*W-W-1:0], b_arr[i]};
    end
    bus.req = req_v;
    bus.opa = pa;
    bus.opb = pb;
  endtask

  // Reference model: one operation at a time, W edges long, winner chosen
  // round-robin (or lowest index) among the levels seen while free.
  function automatic int pick(int r);
    int w;
    w = -1;
`ifdef MULT_ARB_FIXED_PRIO_EN
    for (int k = 0; k < NREQ; k++)
      if (w < 0 && ((r >> k) & 1) == 1) w = k;
`else
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (m_last + k) % NREQ;
      if (w < 0 && ((r >> idx) & 1) == 1) w = idx;
    end
`endif
    return w;
  endfunction

  task automatic model_step();
    int r;
    int w;
    exp_t e;
    ecnt++;
    r = int'(bus.req);
    if (rst) begin
      m_busy = 1'b0;
      m_last = NREQ - 1;
      prod_m = 0;
      gq.delete();
      dq.delete();
    end else if (!m_busy && r != 0) begin
      w      = pick(r);
      prod_p = int'(a_arr[w]) * int'(b_arr[w]);
      e.en   = ecnt;
      e.win  = w;
      e.prod = 0;
      gq.push_back(e);
      e.en   = ecnt + W;
      e.prod = prod_p;
      dq.push_back(e);
      m_busy = 1'b1;
      m_done = ecnt + W;
      m_last = w;
    end else if (m_busy && ecnt == m_done) begin
      m_busy = 1'b0;
      prod_m = prod_p;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Monitor: pops expectations whenever the DUT pulses gnt or done.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (bus.gnt != '0) begin
      if (gq.size() == 0) begin
        check("gnt_unexpected", int'(bus.gnt), 0);
      end else begin
        e = gq.pop_front();
        check("gnt_who", int'(bus.gnt), 1 << e.win);
        check("gnt_when", ecnt, e.en);
      end
    end else if (gq.size() > 0 && gq[0].en <= ecnt) begin
      e = gq.pop_front();
      check("gnt_missing", 0, 1 << e.win);
    end
    if (bus.done != '0) begin
      if (dq.size() == 0) begin
        check("done_unexpected", int'(bus.done), 0);
      end else begin
        e = dq.pop_front();
        check("done_who", int'(bus.done), 1 << e.win);
        check("done_when", ecnt, e.en);
        check("done_prod", int'(bus.product), e.prod);
      end
    end else if (dq.size() > 0 && dq[0].en <= ecnt) begin
      e = dq.pop_front();
      check("done_missing", 0, 1 << e.win);
    end
    check("product", int'(bus.product), prod_m);
    check("busy", int'(bus.busy), int'(m_busy));
  end

  task automatic issue(int i, int a, int b);
    int t;
    a_arr[i] = W'(a);
    b_arr[i] = W'(b);
    req_v    = req_v | (NREQ'(1) << i);
    drive();
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (((int'(bus.gnt) >> i) & 1) == 0 && t < 50);
    if (t >= 50) check("gnt_timeout", 0, 1 << i);
    req_v = req_v & ~(NREQ'(1) << i);
    drive();
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (bus.busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("idle_timeout", int'(bus.busy), 0);
  endtask

  initial begin
    int t;
    int prev;
    int expw;
    rst   = 1'b1;
    req_v = '0;
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = '0;
      b_arr[i] = '0;
    end
    drive();
    repeat (3) @(negedge clk);
    check("rst_gnt", int'(bus.gnt), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_product", int'(bus.product), 0);
    check("rst_busy", int'(bus.busy), 0);
    rst = 1'b0;
    @(negedge clk);

    issue(0, 5, 3);
    wait_idle();
    check("p_5x3", int'(bus.product), 15);
    issue(1, 15, 15);
    wait_idle();
    check("p_15x15", int'(bus.product), 225);
    issue(2, 0, 9);
    wait_idle();
    check("p_0x9", int'(bus.product), 0);

    // Late request on 2 while 3 is running must be ignored.
    issue(3, 7, 6);
    req_v = req_v | NREQ'(4);
    drive();
    repeat (2) @(negedge clk);
    req_v = '0;
    drive();
    wait_idle();
    check("p_7x6", int'(bus.product), 42);
    repeat (3) begin
      @(negedge clk);
      check("late_no_gnt", int'(bus.gnt), 0);
    end
    check("late_hold", int'(bus.product), 42);

    // Reset on the second RUN cycle.
    issue(2, 9, 9);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", int'(bus.busy), 0);
    check("abort_product", int'(bus.product), 0);

    // All requesting, held: one grant every W+1 cycles.
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = W'(i + 3);
      b_arr[i] = W'(2 * i + 1);
    end
    req_v = '1;
    drive();
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (bus.gnt == '0 && t < 20);
      if (t >= 20) check("all_timeout", 0, 1);
`ifdef MULT_ARB_FIXED_PRIO_EN
      expw = 0;
`else
      expw = k % NREQ;
`endif
      check("all_order", int'(bus.gnt), 1 << expw);
      if (k > 0) check("all_interval", ecnt - prev, W + 1);
      prev = ecnt;
    end
    req_v = '0;
    drive();
    @(negedge clk);
    wait_idle();

    // Random traffic: raise with random operands, drop on own grant.
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (((int'(req_v) >> i) & 1) == 1) begin
          if (((int'(bus.gnt) >> i) & 1) == 1)
            req_v = req_v & ~(NREQ'(1) << i);
        end else if ($urandom_range(3) == 0) begin
          a_arr[i] = W'($urandom);
          b_arr[i] = W'($urandom);
          req_v    = req_v | (NREQ'(1) << i);
        end
      end
      drive();
    end
    req_v = '0;
    drive();
    repeat (2 * W + 4) @(negedge clk);
    check("gq_empty", gq.size(), 0);
    check("dq_empty", dq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
